// File: rtl/operator_stack.sv
`default_nettype none
// ============================================================================
// Module   : operator_stack
// Purpose  : LIFO of operator codes with registered top-of-stack on op_data.
//            Optional sticky error flag enabled by macro OPSTACK_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef CO_N
`define CO_N 8
`endif

module operator_stack #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              op_push,
    input  logic              op_pop,
    input  logic              op_clear,
    input  logic [`CO_N-1:0]  op_wdata,
    output logic [`CO_N-1:0]  op_data,
    output logic              op_empty,
    output logic              op_full,
    output logic [AW:0]       op_count,
    output logic              op_err
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_one   = (AW+1)'(1);
    localparam logic [AW:0] c_two   = (AW+1)'(2);

    logic [`CO_N-1:0] r_top;
    logic [AW:0]      r_count;
    logic [`CO_N-1:0] r_mem [0:DEPTH-2];

    logic [`CO_N-1:0] w_top_nxt;
    logic [AW:0]      w_count_nxt;
    logic             w_wr_en;
    logic             w_empty;
    logic             w_full;
    logic [AW:0]      w_cm1;
    logic [AW:0]      w_cm2;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_cm1   = r_count - c_one;
    assign w_cm2   = r_count - c_two;

    always_comb begin
        w_top_nxt   = r_top;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        if (op_clear) begin
            w_top_nxt   = '0;
            w_count_nxt = '0;
        end else if (op_push && op_pop) begin
            // Replace in place; on an empty stack this degenerates to a push.
            w_top_nxt = op_wdata;
            if (w_empty) begin
                w_count_nxt = c_one;
            end
        end else if (op_push) begin
            if (!w_full) begin
                w_top_nxt   = op_wdata;
                w_count_nxt = r_count + c_one;
                w_wr_en     = !w_empty;
            end
        end else if (op_pop) begin
            if (r_count == c_one) begin
                w_top_nxt   = '0;
                w_count_nxt = '0;
            end else if (!w_empty) begin
                w_top_nxt   = r_mem[w_cm2[AW-1:0]];
                w_count_nxt = w_cm1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else begin
            r_top   <= w_top_nxt;
            r_count <= w_count_nxt;
        end
    end

    // The array is never reset; entries above the count are unreachable.
    always_ff @(posedge Clock) begin
        if (!Reset && !op_clear && w_wr_en) begin
            r_mem[w_cm1[AW-1:0]] <= r_top;
        end
    end

`ifdef OPSTACK_ERR_EN
    logic w_err_evt;
    logic r_err;

    assign w_err_evt = ( op_push &&  op_pop && w_empty) ||
                       ( op_push && !op_pop && w_full)  ||
                       (!op_push &&  op_pop && w_empty);

    always_ff @(posedge Clock) begin
        if (Reset || op_clear) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign op_err = r_err;
`else
    assign op_err = 1'b0;
`endif

    assign op_data  = r_top;
    assign op_count = r_count;
    assign op_empty = w_empty;
    assign op_full  = w_full;

endmodule

`default_nettype wire

// File: tb/tb_operator_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_operator_stack
// Purpose  : Scoreboard bench for operator_stack against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef CO_N
`define CO_N 8
`endif

module tb_operator_stack;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int W     = `CO_N;
    localparam int VW    = W + AW + 1 + 3;

    typedef logic [VW-1:0] vec_t;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         op_push;
    logic         op_pop;
    logic         op_clear;
    logic [W-1:0] op_wdata;
    logic [W-1:0] op_data;
    logic         op_empty;
    logic         op_full;
    logic [AW:0]  op_count;
    logic         op_err;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] m_stk[$];
    bit           m_err;
    vec_t         sb[$];

    always #5 Clock = ~Clock;

    operator_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .op_push  (op_push),
        .op_pop   (op_pop),
        .op_clear (op_clear),
        .op_wdata (op_wdata),
        .op_data  (op_data),
        .op_empty (op_empty),
        .op_full  (op_full),
        .op_count (op_count),
        .op_err   (op_err)
    );

    function automatic vec_t actual();
        return {op_data, op_count, op_empty, op_full, op_err};
    endfunction

    function automatic vec_t model_view();
        logic [W-1:0] d;
        logic [AW:0]  c;
        bit           e;
        c = (AW+1)'(m_stk.size());
        d = (m_stk.size() == 0) ? '0 : m_stk[m_stk.size()-1];
`ifdef OPSTACK_ERR_EN
        e = m_err;
`else
        e = 1'b0;
`endif
        return {d, c, (m_stk.size() == 0), (m_stk.size() == DEPTH), e};
    endfunction

    // Drive one cycle, advance the model, queue the expectation, sample after the edge.
    task automatic step(input bit rst, input bit clr, input bit psh, input bit pp,
                        input logic [W-1:0] wd);
        @(negedge Clock);
        Reset = rst; op_clear = clr; op_push = psh; op_pop = pp; op_wdata = wd;
        if (rst || clr) begin
            m_stk.delete();
            m_err = 1'b0;
        end else if (psh && pp) begin
            if (m_stk.size() == 0) begin
                m_stk.push_back(wd);
                m_err = 1'b1;
            end else begin
                m_stk[m_stk.size()-1] = wd;
            end
        end else if (psh) begin
            if (m_stk.size() == DEPTH) m_err = 1'b1;
            else m_stk.push_back(wd);
        end else if (pp) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else void'(m_stk.pop_back());
        end
        sb.push_back(model_view());
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        vec_t exp;
        step(1, 0, 1, 0, 8'h5A);
        exp = sb.pop_front();
        n_vec++;
        if (actual() !== exp || exp !== {{W{1'b0}}, {(AW+1){1'b0}}, 3'b100}) begin
            n_err++;
            $display("FAIL reset: got %h expected %h", actual(), exp);
        end
    endtask

    task automatic test_basic();
        bit           t_psh[7] = '{1, 1, 1, 0, 0, 0, 0};
        bit           t_pop[7] = '{0, 0, 0, 1, 1, 1, 1};
        logic [W-1:0] t_wd[7]  = '{3, 5, 7, 0, 0, 0, 0};
        vec_t exp;
        for (int i = 0; i < 7; i++) begin
            step(0, 0, t_psh[i], t_pop[i], t_wd[i]);
            exp = sb.pop_front();
            n_vec++;
            if (actual() !== exp) begin
                n_err++;
                $display("FAIL basic[%0d]: got %h expected %h", i, actual(), exp);
            end
        end
    endtask

    task automatic test_full();
        vec_t exp;
        step(0, 1, 0, 0, 0);
        void'(sb.pop_front());
        for (int i = 1; i <= DEPTH + 2; i++) begin
            if (i <= DEPTH) step(0, 0, 1, 0, W'(i));
            else            step(0, 0, 1, 0, W'(9));
            exp = sb.pop_front();
            n_vec++;
            if (actual() !== exp) begin
                n_err++;
                $display("FAIL full[%0d]: got %h expected %h", i, actual(), exp);
            end
        end
        // Replace while full is legal and error-free in the model's own terms.
        step(0, 0, 1, 1, W'(8'hEE));
        exp = sb.pop_front();
        n_vec++;
        if (actual() !== exp) begin
            n_err++;
            $display("FAIL full_replace: got %h expected %h", actual(), exp);
        end
    endtask

    task automatic test_underflow();
        bit t_clr[4] = '{1, 0, 0, 1};
        bit t_pop[4] = '{0, 1, 1, 0};
        vec_t exp;
        for (int i = 0; i < 4; i++) begin
            step(0, t_clr[i], 0, t_pop[i], 0);
            exp = sb.pop_front();
            n_vec++;
            if (actual() !== exp) begin
                n_err++;
                $display("FAIL underflow[%0d]: got %h expected %h", i, actual(), exp);
            end
        end
    endtask

    task automatic test_push_pop();
        bit           t_clr[7] = '{1, 0, 0, 0, 0, 1, 0};
        bit           t_psh[7] = '{0, 1, 1, 1, 0, 0, 1};
        bit           t_pop[7] = '{0, 0, 0, 1, 1, 0, 1};
        logic [W-1:0] t_wd[7]  = '{0, 2, 4, 6, 0, 0, 8'h33};
        vec_t exp;
        for (int i = 0; i < 7; i++) begin
            step(0, t_clr[i], t_psh[i], t_pop[i], t_wd[i]);
            exp = sb.pop_front();
            n_vec++;
            if (actual() !== exp) begin
                n_err++;
                $display("FAIL push_pop[%0d]: got %h expected %h", i, actual(), exp);
            end
        end
    endtask

    task automatic test_priority();
        bit           t_rst[9] = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
        bit           t_clr[9] = '{0, 0, 0, 0, 1, 0, 1, 0, 0};
        bit           t_psh[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        bit           t_pop[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
        logic [W-1:0] t_wd[9]  = '{0, 1, 2, 3, 8, 8, 8, 8'h44, 0};
        vec_t exp;
        for (int i = 0; i < 9; i++) begin
            step(t_rst[i], t_clr[i], t_psh[i], t_pop[i], t_wd[i]);
            exp = sb.pop_front();
            n_vec++;
            if (actual() !== exp) begin
                n_err++;
                $display("FAIL priority[%0d]: got %h expected %h", i, actual(), exp);
            end
        end
    endtask

    task automatic test_random();
        vec_t exp;
        int   r;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            step(r == 0, r == 1, (r >= 2 && r < 60) || (r >= 90),
                 (r >= 50 && r < 90) || (r >= 95), W'($urandom));
            exp = sb.pop_front();
            n_vec++;
            if (actual() !== exp) begin
                n_err++;
                $display("FAIL random[%0d]: got %h expected %h", i, actual(), exp);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; op_clear = 1'b0; op_push = 1'b0; op_pop = 1'b0; op_wdata = '0;
        m_err = 1'b0;
        repeat (2) @(posedge Clock);
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_push_pop();
        test_priority();
        test_random();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
